regfile: RTL and testbench

//   General-purpose register file; the responder to the decode stage's two register read requests.
//   - Decode drives re1/raddr1 and re2/raddr2 and receives rdata1/rdata2 in the same cycle.
//   - Write-back drives we/waddr/wdata; the write commits on the next rising clk.
//   - Holds 32 x 32-bit MIPS registers. $0 is hardwired to zero.
//   - Bypasses a same-cycle write-back to a read port, so decode never sees stale data.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_if.sv | 33 +++
 rtl/regfile_rd_port.sv | 31 +++
 rtl/regfile.sv | 53 +++++
 tb/tb_regfile.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, constants and helpers for the general-purpose register file.
package regfile_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam word_t ZERO_WORD    = '0;
    localparam addr_t NOP_REG_ADDR = '0;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;

    // Reset is active-low across the whole pipeline
    localparam logic RST_ENABLE    = 1'b0;

    // Register $0 is hardwired to zero and never holds written data
    function automatic logic is_zero_reg(addr_t addr);
        return addr == NOP_REG_ADDR;
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Bundle of the write-back port and the two decode read ports of the register file.
interface regfile_if;
    import regfile_pkg::*;

    logic  we;
    addr_t waddr;
    word_t wdata;

    logic  re1;
    addr_t raddr1;
    word_t rdata1;

    logic  re2;
    addr_t raddr2;
    word_t rdata2;

    // Pipeline side: drives requests, receives read data
    modport master (
        output we, waddr, wdata,
        output re1, raddr1,
        output re2, raddr2,
        input  rdata1, rdata2
    );

    // Register file side
    modport slave (
        input  we, waddr, wdata,
        input  re1, raddr1,
        input  re2, raddr2,
        output rdata1, rdata2
    );

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: reset/enable/$0 gating, then same-cycle write bypass, then storage.
module regfile_rd_port
    import regfile_pkg::*;
(
    input  logic  rst,
    input  logic  re,
    input  addr_t raddr,
    input  logic  we,
    input  addr_t waddr,
    input  word_t wdata,
    input  word_t word,
    output word_t rdata
);

    // Priority mux; $0 check precedes the bypass so a write to $0 never leaks out
    always_comb begin
        rdata = ZERO_WORD;
        if (rst == RST_ENABLE) begin
            rdata = ZERO_WORD;
        end else if (re != READ_ENABLE) begin
            rdata = ZERO_WORD;
        end else if (is_zero_reg(raddr)) begin
            rdata = ZERO_WORD;
        end else if (we == WRITE_ENABLE && waddr == raddr) begin
            rdata = wdata;
        end else begin
            rdata = word;
        end
    end

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit MIPS register file with two bypassed combinational read ports and one write port.
module regfile
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    regfile_if.slave  rf
);

    word_t regs_q [NUM_REGS];
    word_t regs_d [NUM_REGS];

    // Next-state storage: commit the write-back unless it targets $0
    always_comb begin
        regs_d = regs_q;
        if (rf.we == WRITE_ENABLE && !is_zero_reg(rf.waddr)) begin
            regs_d[rf.waddr] = rf.wdata;
        end
        regs_d[0] = ZERO_WORD;
    end

    // Storage register; asynchronous reset clears every entry and drops any in-flight write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '{default: ZERO_WORD};
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_rd_port u_rd_port1 (
        .rst   (rst),
        .re    (rf.re1),
        .raddr (rf.raddr1),
        .we    (rf.we),
        .waddr (rf.waddr),
        .wdata (rf.wdata),
        .word  (regs_q[rf.raddr1]),
        .rdata (rf.rdata1)
    );

    regfile_rd_port u_rd_port2 (
        .rst   (rst),
        .re    (rf.re2),
        .raddr (rf.raddr2),
        .we    (rf.we),
        .waddr (rf.waddr),
        .wdata (rf.wdata),
        .word  (regs_q[rf.raddr2]),
        .rdata (rf.rdata2)
    );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic against an array model.
module tb_regfile;

    logic clk;
    logic rst;

    regfile_if rif ();

    regfile dut (
        .clk (clk),
        .rst (rst),
        .rf  (rif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural register contents
    logic [31:0] mem [32];
    int errors = 0;
    int checks = 0;

    // Expected read value derived from the architectural read rules
    function automatic logic [31:0] exp_read(input logic re, input logic [4:0] ra);
        if (!rst)                          return 32'h0;
        if (!re)                           return 32'h0;
        if (ra == 5'd0)                    return 32'h0;
        if (rif.we && rif.waddr == ra)     return rif.wdata;
        return mem[ra];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    endtask

    // Advance one clock; commit into the model what the edge should store
    task automatic tick();
        @(posedge clk);
        if (rst && rif.we && rif.waddr != 5'd0) mem[rif.waddr] = rif.wdata;
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re1, input logic [4:0] ra1,
                         input logic re2, input logic [4:0] ra2);
        rif.we     = we;
        rif.waddr  = wa;
        rif.wdata  = wd;
        rif.re1    = re1;
        rif.raddr1 = ra1;
        rif.re2    = re2;
        rif.raddr2 = ra2;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b1, 5'd5);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (rif.rdata1 !== 32'h0) begin
                errors++;
                $display("FAIL reset_rdata1 cyc=%0d got=%h exp=%h", c, rif.rdata1, 32'h0);
            end
            checks++;
            if (rif.rdata2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_rdata2 cyc=%0d got=%h exp=%h", c, rif.rdata2, 32'h0);
            end
            tick();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
        rst = 1'b1;
        #1;
        checks++;
        if (rif.rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_after_release r5 got=%h exp=%h", rif.rdata1, 32'h0);
        end
        tick();
    endtask

    task automatic test_write_read();
        drive(1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3);
        checks++;
        if (rif.rdata1 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL write_read r3 got=%h exp=%h", rif.rdata1, 32'h1234_5678);
        end
        checks++;
        if (rif.rdata2 !== 32'h0) begin
            errors++;
            $display("FAIL read_disabled port2 got=%h exp=%h", rif.rdata2, 32'h0);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 1'b0, 5'd3);
        checks++;
        if (rif.rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL read_disabled port1 got=%h exp=%h", rif.rdata1, 32'h0);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0);
        checks++;
        if (rif.rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL zero_during_write got=%h exp=%h", rif.rdata1, 32'h0);
        end
        checks++;
        if (rif.rdata2 !== 32'h0) begin
            errors++;
            $display("FAIL zero_during_write_p2 got=%h exp=%h", rif.rdata2, 32'h0);
        end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0);
        checks++;
        if (rif.rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL zero_after_write got=%h exp=%h", rif.rdata1, 32'h0);
        end
        tick();
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd7, 32'hAAAA_0000, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b1, 5'd7, 32'h0000_5555, 1'b1, 5'd7, 1'b1, 5'd7);
        checks++;
        if (rif.rdata1 !== 32'h0000_5555) begin
            errors++;
            $display("FAIL bypass_p1 got=%h exp=%h", rif.rdata1, 32'h0000_5555);
        end
        checks++;
        if (rif.rdata2 !== 32'h0000_5555) begin
            errors++;
            $display("FAIL bypass_p2 got=%h exp=%h", rif.rdata2, 32'h0000_5555);
        end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
        checks++;
        if (rif.rdata1 !== 32'h0000_5555) begin
            errors++;
            $display("FAIL bypass_committed got=%h exp=%h", rif.rdata1, 32'h0000_5555);
        end
        tick();
    endtask

    task automatic test_independent_ports();
        drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd4, 1'b1, 5'd9);
        checks++;
        if (rif.rdata1 !== 32'h44) begin
            errors++;
            $display("FAIL indep_p1 got=%h exp=%h", rif.rdata1, 32'h44);
        end
        checks++;
        if (rif.rdata2 !== 32'h99) begin
            errors++;
            $display("FAIL indep_p2 got=%h exp=%h", rif.rdata2, 32'h99);
        end
        tick();
    endtask

    task automatic test_random();
        logic [4:0] wa;
        for (int c = 0; c < 300; c++) begin
            wa = 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 3) != 0), wa, $urandom,
                  1'($urandom_range(0, 5) != 0),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 5) != 0),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
            checks++;
            if (rif.rdata1 !== exp_read(rif.re1, rif.raddr1)) begin
                errors++;
                $display("FAIL random_p1 cyc=%0d ra=%0d got=%h exp=%h", c, rif.raddr1,
                         rif.rdata1, exp_read(rif.re1, rif.raddr1));
            end
            checks++;
            if (rif.rdata2 !== exp_read(rif.re2, rif.raddr2)) begin
                errors++;
                $display("FAIL random_p2 cyc=%0d ra=%0d got=%h exp=%h", c, rif.raddr2,
                         rif.rdata2, exp_read(rif.re2, rif.raddr2));
            end
            tick();
        end
    endtask

    task automatic test_async_reset_mid_write();
        // Fill every writable register so the sweep proves clearing
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 1'b0, 5'd0);
            tick();
        end
        drive(1'b1, 5'd10, 32'h10, 1'b1, 5'd10, 1'b1, 5'd3);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        #1;
        checks++;
        if (rif.rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_rdata got=%h exp=%h", rif.rdata1, 32'h0);
        end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        rst = 1'b1;
        #1;
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i + 1));
            checks++;
            if (rif.rdata1 !== 32'h0) begin
                errors++;
                $display("FAIL sweep_p1 r%0d got=%h exp=%h", i, rif.rdata1, 32'h0);
            end
            checks++;
            if (rif.rdata2 !== 32'h0) begin
                errors++;
                $display("FAIL sweep_p2 r%0d got=%h exp=%h", 32 - i, rif.rdata2, 32'h0);
            end
        end
        tick();
    endtask

    initial begin
        clear_model();
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_independent_ports();
        test_random();
        test_async_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
